// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared-memory datapath; traps illegal instructions and counts retirements.
// Ports: clk, rst (async active-low); op/func/zero/mem_ready from the datapath
// and memory; datapath enables and mux selects out; illegal (sticky) and retired.
module mips_multicycle_ctrl #(
  parameter int ALUOP_W         = 3,
  parameter int CNT_W           = 16,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op,
  input  logic [5:0]         func,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_src,
  output logic [1:0]         reg_dest,
  output logic [1:0]         mem_to_reg,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXEC_R = 4'd2;
  localparam logic [3:0] S_RWB    = 4'd3;
  localparam logic [3:0] S_MEMADR = 4'd4;
  localparam logic [3:0] S_MEMRD  = 4'd5;
  localparam logic [3:0] S_MEMWB  = 4'd6;
  localparam logic [3:0] S_MEMWR  = 4'd7;
  localparam logic [3:0] S_BEQ    = 4'd8;
  localparam logic [3:0] S_EXEC_I = 4'd9;
  localparam logic [3:0] S_IWB    = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_JAL    = 4'd12;
  localparam logic [3:0] S_JR     = 4'd13;
  localparam logic [3:0] S_TRAP   = 4'd14;

  localparam logic [2:0] A_ADD = 3'b000;
  localparam logic [2:0] A_SUB = 3'b001;
  localparam logic [2:0] A_AND = 3'b010;
  localparam logic [2:0] A_OR  = 3'b011;
  localparam logic [2:0] A_SLT = 3'b100;

  logic [3:0] state, nxt;
  logic [2:0] r_alu, alu3;
  logic       r_ok, is_jr, bad, retire;

  always_comb begin
    r_ok  = 1'b1;
    r_alu = A_ADD;
    case (func)
      6'b100000: r_alu = A_ADD;
      6'b100010: r_alu = A_SUB;
      6'b100100: r_alu = A_AND;
      6'b100101: r_alu = A_OR;
      6'b101010: r_alu = A_SLT;
      default:   r_ok  = 1'b0;
    endcase
  end

  assign is_jr = (func == 6'b001000);

  always_comb begin
    nxt = state;
    bad = 1'b0;
    case (state)
      S_FETCH:  if (mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          6'b000000: begin
            if (is_jr)     nxt = S_JR;
            else if (r_ok) nxt = S_EXEC_R;
            else           bad = 1'b1;
          end
          6'b100011,
          6'b101011: nxt = S_MEMADR;
          6'b000100: nxt = S_BEQ;
          6'b001000,
          6'b001010: nxt = S_EXEC_I;
          6'b000010: nxt = S_JUMP;
          6'b000011: nxt = S_JAL;
          default:   bad = 1'b1;
        endcase
        if (bad) nxt = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
      end
      S_EXEC_R: nxt = S_RWB;
      S_MEMADR: nxt = (op == 6'b100011) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) nxt = S_MEMWB;
      S_MEMWR:  if (mem_ready) nxt = S_FETCH;
      S_EXEC_I: nxt = S_IWB;
      S_TRAP:   nxt = S_TRAP;
      default:  nxt = S_FETCH;
    endcase
  end

  // DECODE only reaches FETCH as an illegal nop, so it never retires.
  assign retire = (nxt == S_FETCH) && (state != S_FETCH)
               && (state != S_DECODE) && (state != S_TRAP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_FETCH;
      retired <= '0;
      illegal <= 1'b0;
    end else begin
      state <= nxt;
      if (retire) retired <= retired + CNT_W'(1);
      if (bad)    illegal <= 1'b1;
    end
  end

  // Outputs are forced low while rst is asserted so an in-flight
  // access is dropped immediately, not at the next edge.
  always_comb begin
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu3       = A_ADD;
    pc_src     = 2'b00;
    reg_dest   = 2'b00;
    mem_to_reg = 2'b00;
    if (rst) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: alu_src_b = 2'b11;
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu3      = r_alu;
        end
        S_RWB: begin
          reg_write = 1'b1;
          reg_dest  = 2'b01;
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'b01;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_BEQ: begin
          alu_src_a = 1'b1;
          alu3      = A_SUB;
          pc_src    = 2'b01;
          pc_write  = zero;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu3      = (op == 6'b001010) ? A_SLT : A_ADD;
        end
        S_IWB: reg_write = 1'b1;
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end
        S_JAL: begin
          pc_write   = 1'b1;
          pc_src     = 2'b10;
          reg_write  = 1'b1;
          reg_dest   = 2'b10;
          mem_to_reg = 2'b10;
        end
        S_JR: begin
          pc_write = 1'b1;
          pc_src   = 2'b11;
        end
        default: ;
      endcase
    end
  end

  assign alu_op = ALUOP_W'(alu3);

endmodule
